// File: rtl/pmips_trace_buffer_if.sv
// pmips_trace_buffer_if: processor tap, trigger control and readout port of the trace buffer (TRACE_DMEM_EN adds dmemaddr/dmemwdata)
interface pmips_trace_buffer_if #(
  parameter int W = 16,
  parameter int DEPTH_LOG2 = 5
);
`ifdef TRACE_DMEM_EN
  localparam int EW = 4 * W + 3;
  logic [W-1:0] dmemaddr;
  logic [W-1:0] dmemwdata;
`else
  localparam int EW = 2 * W + 3;
`endif
  logic [W-1:0] imemaddr;
  logic [W-1:0] imemrdata;
  logic dmemwrite;
  logic stall;
  logic flush;
  logic arm;
  logic [W-1:0] trig_pc;
  logic rd_en;
  logic [EW-1:0] rd_data;
  logic rd_valid;
  logic rd_last;
  logic triggered;
  logic done;
  logic [DEPTH_LOG2:0] entries;
  modport master (
`ifdef TRACE_DMEM_EN
    output dmemaddr, dmemwdata,
`endif
    output imemaddr, imemrdata, dmemwrite, stall, flush, arm, trig_pc, rd_en,
    input rd_data, rd_valid, rd_last, triggered, done, entries
  );
  modport slave (
`ifdef TRACE_DMEM_EN
    input dmemaddr, dmemwdata,
`endif
    input imemaddr, imemrdata, dmemwrite, stall, flush, arm, trig_pc, rd_en,
    output rd_data, rd_valid, rd_last, triggered, done, entries
  );
endinterface

// File: rtl/pmips_trace_buffer.sv
// pmips_trace_buffer: circular PMIPS fetch trace around a trigger PC, played back oldest-first (TRACE_DMEM_EN adds store address/data)
module pmips_trace_buffer #(
  parameter int W = 16,
  parameter int DEPTH_LOG2 = 5,
  parameter int PRE_TRIG = 8
) (
  input logic clock,
  input logic reset,
  pmips_trace_buffer_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef TRACE_DMEM_EN
  localparam int EW = 4 * W + 3;
`else
  localparam int EW = 2 * W + 3;
`endif
  localparam logic [DEPTH_LOG2-1:0] POST_LOAD = DEPTH_LOG2'(DEPTH - 1 - PRE_TRIG);
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  state_t state, state_n;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] entry, rd_data;
  logic [DEPTH_LOG2-1:0] wptr, rptr, post;
  logic [DEPTH_LOG2:0] ent, ent_inc, rcnt;
  logic cap, hit, rd, last, rd_valid, rd_last, triggered;
`ifdef TRACE_DMEM_EN
  assign entry = {bus.imemaddr, bus.imemrdata, bus.dmemaddr, bus.dmemwdata, bus.dmemwrite, bus.stall, bus.flush};
`else
  assign entry = {bus.imemaddr, bus.imemrdata, bus.dmemwrite, bus.stall, bus.flush};
`endif
  always_comb begin
    cap = (state == ARMED || state == POST) && !bus.stall && !bus.arm;
    hit = cap && state == ARMED && bus.imemaddr == bus.trig_pc;
    rd = state == DONE && bus.rd_en && !bus.arm;
    last = rcnt + 1'b1 == ent;
    ent_inc = ent == FULL ? ent : ent + 1'b1;
    state_n = state;
    if (bus.arm) state_n = ARMED;
    else if (hit) state_n = POST_LOAD == '0 ? DONE : POST;
    else if (state == POST && cap && post == 1) state_n = DONE;
    else if (rd && last) state_n = IDLE;
  end
  always_ff @(posedge clock) if (cap) mem[wptr] <= entry;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      post <= '0;
      ent <= '0;
      rcnt <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      triggered <= 1'b0;
    end else begin
      state <= state_n;
      rd_valid <= rd;
      rd_last <= rd && last;
      if (bus.arm) begin
        wptr <= '0;
        ent <= '0;
        triggered <= 1'b0;
      end else begin
        if (cap) begin
          wptr <= wptr + 1'b1;
          ent <= ent_inc;
        end
        if (hit) begin
          triggered <= 1'b1;
          post <= POST_LOAD;
        end else if (state == POST && cap) post <= post - 1'b1;
        // a full buffer has wrapped, so its oldest entry sits at the next write slot
        if (state_n == DONE && state != DONE) begin
          rptr <= ent_inc == FULL ? wptr + 1'b1 : '0;
          rcnt <= '0;
        end
        if (rd) begin
          rd_data <= mem[rptr];
          rptr <= rptr + 1'b1;
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end
  assign bus.rd_data = rd_data;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_last = rd_last;
  assign bus.triggered = triggered;
  assign bus.done = state == DONE;
  assign bus.entries = ent;
endmodule

// File: tb/tb_pmips_trace_buffer.sv
// tb_pmips_trace_buffer: scoreboard bench for pmips_trace_buffer (define TRACE_DMEM_EN to cover the store fields)
module tb_pmips_trace_buffer;
  localparam int W = 16;
  localparam int DEPTH = 32;
  localparam int PRE = 8;
`ifdef TRACE_DMEM_EN
  localparam int EW = 4 * W + 3;
`else
  localparam int EW = 2 * W + 3;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [EW-1:0] hist[$];
  logic [EW-1:0] exp_q[$];
  int exp_entries;
  pmips_trace_buffer_if bus ();
  pmips_trace_buffer dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [W-1:0] instr_of(input logic [W-1:0] pc);
    return (pc * 16'd3) ^ 16'h1234;
  endfunction
  function automatic logic [W-1:0] daddr_of(input logic [W-1:0] pc);
    return pc == 16'd20 ? 16'hFFF0 : ~pc;
  endfunction
  function automatic logic [W-1:0] dwdata_of(input logic [W-1:0] pc);
    return pc == 16'd20 ? 16'h0005 : pc + 16'd7;
  endfunction
  function automatic logic [EW-1:0] mk(input logic [W-1:0] pc);
`ifdef TRACE_DMEM_EN
    return {pc, instr_of(pc), daddr_of(pc), dwdata_of(pc), pc[2], 1'b0, pc[3]};
`else
    return {pc, instr_of(pc), pc[2], 1'b0, pc[3]};
`endif
  endfunction
  task automatic drive(input logic [W-1:0] pc, input logic st);
    bus.imemaddr = pc;
    bus.imemrdata = instr_of(pc);
    bus.dmemwrite = pc[2];
    bus.flush = pc[3];
    bus.stall = st;
`ifdef TRACE_DMEM_EN
    bus.dmemaddr = daddr_of(pc);
    bus.dmemwdata = dwdata_of(pc);
`endif
    @(posedge clock);
    #1;
  endtask
  task automatic arm_pulse(input logic [W-1:0] tpc);
    bus.trig_pc = tpc;
    bus.arm = 1'b1;
    drive(tpc, 1'b0);
    bus.arm = 1'b0;
  endtask
  // model: after the trigger capture exactly DEPTH-1-PRE more entries, keep the newest DEPTH
  task automatic capture(input logic [W-1:0] tpc, input bit stall_10_12);
    bit trig = 0;
    bit early = 0;
    int post = 0;
    int k;
    logic [W-1:0] pc = 0;
    arm_pulse(tpc);
    check("arm_entries", bus.entries, 0);
    check("arm_triggered", bus.triggered, 0);
    hist.delete();
    while (!(trig && post == 0) && pc < 16'd400) begin
      if (bus.done) early = 1;
      if (stall_10_12 && (pc == 16'd10 || pc == 16'd12)) begin
        drive(pc, 1'b1);
        if (pc == tpc) check("stall_no_trig", bus.triggered, 0);
      end
      drive(pc, 1'b0);
      hist.push_back(mk(pc));
      if (!trig && pc == tpc) begin
        trig = 1;
        post = DEPTH - 1 - PRE;
        check("triggered", bus.triggered, 1);
      end else if (trig) post--;
      pc += 16'd2;
    end
    if (early) check("done_early", early, 0);
    check("done", bus.done, 1);
    k = hist.size() > DEPTH ? hist.size() - DEPTH : 0;
    exp_entries = hist.size() - k;
    exp_q.delete();
    for (int i = k; i < hist.size(); i++) exp_q.push_back(hist[i]);
    check("entries", bus.entries, exp_entries);
  endtask
  task automatic readout(input int target, input logic [W-1:0] tpc, input int want_pos,
                         output logic [W-1:0] first_pc, output logic [W-1:0] last_pc);
    int issued = 0;
    int got = 0;
    int cyc = 0;
    int pos = -1;
    logic [EW-1:0] e;
    first_pc = 'x;
    last_pc = 'x;
    while (got < target && cyc < 400) begin
      bus.rd_en = issued < target && $urandom_range(0, 3) != 0;
      if (bus.rd_en) issued++;
      @(posedge clock);
      #1;
      cyc++;
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) check("spurious_valid", bus.rd_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("rd_data", bus.rd_data, e);
          check("rd_last", bus.rd_last, exp_q.size() == 0);
          if (got == 0) first_pc = bus.rd_data[EW-1 -: W];
          last_pc = bus.rd_data[EW-1 -: W];
          if (bus.rd_data[EW-1 -: W] == tpc) pos = got;
`ifdef TRACE_DMEM_EN
          if (bus.rd_data[EW-1 -: W] == 16'd20) begin
            check("store_we", bus.rd_data[2], 1);
            check("store_addr", bus.rd_data[3+W +: W], 16'hFFF0);
            check("store_data", bus.rd_data[3 +: W], 16'h0005);
          end
`endif
        end
        got++;
      end
    end
    bus.rd_en = 1'b0;
    if (got < target) check("read_timeout", got, target);
    if (want_pos >= 0) check("trig_pos", pos, want_pos);
  endtask
  initial begin
    logic [W-1:0] fp, lp;
    bus.arm = 1'b0;
    bus.rd_en = 1'b0;
    bus.trig_pc = '0;
    bus.imemaddr = '0;
    bus.imemrdata = '0;
    bus.dmemwrite = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
`ifdef TRACE_DMEM_EN
    bus.dmemaddr = '0;
    bus.dmemwdata = '0;
`endif
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_done", bus.done, 0);
    check("rst_entries", bus.entries, 0);
    check("rst_valid", bus.rd_valid, 0);
    check("rst_last", bus.rd_last, 0);
    check("rst_triggered", bus.triggered, 0);
    check("rst_data", bus.rd_data, 0);
    bus.rd_en = 1'b1;
    repeat (3) drive(16'd0, 1'b0);
    check("idle_rd_ignored", bus.rd_valid, 0);
    bus.rd_en = 1'b0;
    capture(16'd40, 0);
    check("t1_entries", bus.entries, 32);
    readout(exp_entries, 16'd40, 8, fp, lp);
    check("t1_first_pc", fp, 16'd24);
    check("t1_last_pc", lp, 16'd86);
    check("t1_done_clear", bus.done, 0);
    capture(16'd6, 0);
    check("t2_entries", bus.entries, 27);
    readout(exp_entries, 16'd6, 3, fp, lp);
    check("t2_first_pc", fp, 16'd0);
    check("t2_last_pc", lp, 16'd52);
    capture(16'd12, 1);
    check("t3_entries", bus.entries, 30);
    readout(exp_entries, 16'd12, 6, fp, lp);
    arm_pulse(16'd8);
    for (int i = 0; i < 8; i++) drive(16'(2 * i), 1'b0);
    check("t4_post_triggered", bus.triggered, 1);
    check("t4_post_entries", bus.entries, 8);
    capture(16'd30, 0);
    readout(exp_entries, 16'd30, 8, fp, lp);
    check("t4_first_pc", fp, 16'd14);
    capture(16'd40, 0);
    bus.rd_en = 1'b1;
    arm_pulse(16'd40);
    bus.rd_en = 1'b0;
    check("armrd_valid", bus.rd_valid, 0);
    check("armrd_entries", bus.entries, 0);
    check("armrd_done", bus.done, 0);
    capture(16'd40, 0);
    readout(5, 16'hFFFF, -1, fp, lp);
    check("t5_first_pc", fp, 16'd24);
    bus.rd_en = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("t5_valid", bus.rd_valid, 0);
    check("t5_done", bus.done, 0);
    check("t5_entries", bus.entries, 0);
    check("t5_triggered", bus.triggered, 0);
    begin
      bit seen = 0;
      repeat (5) begin
        @(posedge clock);
        #1;
        if (bus.rd_valid) seen = 1;
      end
      check("t5_no_data", seen, 0);
    end
    bus.rd_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
